// File: rtl/ps2_rx.sv
// Receive-only PS/2 keyboard port: pin conditioning, frame FSM, byte FIFO and DATA/STAT registers.
// Optional macro PS2_PARITY_CHK_EN enables odd-parity checking and the PERR flag (STAT bit 4).
module ps2_rx #(
    parameter int CLK_HZ      = 16000000,
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 16000,
    parameter int FIFO_AW     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       we,
    input  logic       addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0] FILT_MAX = 4'(FILT_LEN - 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC - 1);
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

    // Line index 0 = PS/2 clock, 1 = PS/2 data.
    logic [1:0] sync1_q, sync2_q, filt_q, filt_d;
    logic [3:0] fcnt_q [2];
    logic [3:0] fcnt_d [2];
    logic       fclk_prev_q;
    logic       strobe, bit_in;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            filt_d[i] = filt_q[i];
            fcnt_d[i] = 4'd0;
            if (sync2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == FILT_MAX) filt_d[i] = sync2_q[i];
                else fcnt_d[i] = fcnt_q[i] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            filt_q      <= 2'b11;
            fcnt_q[0]   <= 4'd0;
            fcnt_q[1]   <= 4'd0;
            fclk_prev_q <= 1'b1;
        end else begin
            sync1_q     <= {ps2_dat_i, ps2_clk_i};
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            fcnt_q[0]   <= fcnt_d[0];
            fcnt_q[1]   <= fcnt_d[1];
            fclk_prev_q <= filt_q[0];
        end
    end

    assign strobe = fclk_prev_q & ~filt_q[0];
    assign bit_in = filt_q[1];

    state_t        state_q, state_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          push_q, push_d;
    logic          ferr_set, tout_set, perr_set;
    logic          parity_ok;

    assign parity_ok = ^{par_q, shift_q};

    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        tcnt_d   = '0;
        push_d   = 1'b0;
        ferr_set = 1'b0;
        tout_set = 1'b0;
        perr_set = 1'b0;
        if (state_q != ST_IDLE && !strobe) tcnt_d = tcnt_q + 1'b1;
        case (state_q)
            ST_IDLE: if (strobe && !bit_in) begin
                state_d = ST_DATA;
                bcnt_d  = 3'd0;
            end
            ST_DATA: if (strobe) begin
                shift_d = {bit_in, shift_q[7:1]};
                bcnt_d  = bcnt_q + 3'd1;
                if (bcnt_q == 3'd7) state_d = ST_PARITY;
            end
            ST_PARITY: if (strobe) begin
                par_d   = bit_in;
                state_d = ST_STOP;
            end
            ST_STOP: if (strobe) begin
                state_d = ST_IDLE;
                if (!bit_in) ferr_set = 1'b1;
`ifdef PS2_PARITY_CHK_EN
                else if (!parity_ok) perr_set = 1'b1;
`endif
                else push_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort a stalled frame; the partial byte is simply never pushed.
        if (state_q != ST_IDLE && !strobe && tcnt_q == TO_MAX) begin
            state_d  = ST_IDLE;
            tout_set = 1'b1;
            tcnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            bcnt_q  <= 3'd0;
            shift_q <= 8'h00;
            par_q   <= 1'b0;
            tcnt_q  <= '0;
            push_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tcnt_q  <= tcnt_d;
            push_q  <= push_d;
        end
    end

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wptr_q, rptr_q;
    logic [FIFO_AW:0]   cnt_q, cnt_d;
    logic               empty, full, pop, do_push, ovr_set, stat_wr;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == FULL_CNT);
    assign pop     = cs & ~we & ~addr & ~empty;
    assign do_push = push_q & (~full | pop);
    assign ovr_set = push_q & full & ~pop;
    assign stat_wr = cs & we & addr;

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !pop) cnt_d = cnt_q + 1'b1;
        else if (pop && !do_push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= shift_q;
    end

    logic ie_q, ovr_q, tout_q, ferr_q, perr_q;

    // Set beats a same-cycle write-1-to-clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ie_q   <= 1'b0;
            ovr_q  <= 1'b0;
            tout_q <= 1'b0;
            ferr_q <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            cnt_q  <= cnt_d;
            if (stat_wr) ie_q <= din[7];
            ovr_q  <= ovr_set  | (ovr_q  & ~(stat_wr & din[1]));
            tout_q <= tout_set | (tout_q & ~(stat_wr & din[2]));
            ferr_q <= ferr_set | (ferr_q & ~(stat_wr & din[3]));
            perr_q <= perr_set | (perr_q & ~(stat_wr & din[4]));
        end
    end

    logic perr_bit;
`ifdef PS2_PARITY_CHK_EN
    assign perr_bit = perr_q;
    logic unused_sig;
    assign unused_sig = ^{din[6:5], din[0], (CLK_HZ != 0)};
`else
    assign perr_bit = 1'b0;
    logic unused_sig;
    assign unused_sig = ^{din[6:5], din[0], perr_q, parity_ok, (CLK_HZ != 0)};
`endif

    logic [7:0] stat;
    assign stat = {ie_q, 2'b00, perr_bit, ferr_q, tout_q, ovr_q, ~empty};
    assign dout = addr ? stat : (empty ? 8'h00 : mem_q[rptr_q]);
    assign irq  = ie_q & ~empty;
endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: drives PS/2 frames on the pins and checks the register view.
module tb_ps2_rx;
    localparam int HALF = 24;
    localparam int TO   = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cs = 1'b0, we = 1'b0, addr = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       irq;
    logic       ps2_clk = 1'b1, ps2_dat = 1'b1;
    int         passed = 0, total = 0;
    logic [7:0] rd;

    ps2_rx #(.CLK_HZ(16000000), .FILT_LEN(8), .TIMEOUT_CYC(TO), .FIFO_AW(2)) dut (
        .clk(clk), .reset(reset), .cs(cs), .we(we), .addr(addr), .din(din),
        .dout(dout), .irq(irq), .ps2_clk_i(ps2_clk), .ps2_dat_i(ps2_dat)
    );

    always #5 clk = ~clk;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    endtask

    task automatic reg_read(input logic a, output logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b0; addr = a;
        #1 d = dout;
        @(negedge clk);
        cs = 1'b0;
    endtask

    task automatic reg_write(input logic a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; addr = a; din = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_dat = bits[i];
            wait_clk(HALF / 2);
            ps2_clk = 1'b0;
            wait_clk(HALF);
            ps2_clk = 1'b1;
            wait_clk(HALF / 2);
        end
        ps2_dat = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic good_par, input logic stop);
        logic par;
        par = good_par ? ~^d : ^d;
        send_bits({stop, par, d, 1'b0}, 11);
        wait_clk(20);
    endtask

    initial begin
        // Reset state
        wait_clk(3);
        addr = 1'b0; #1 check("rst_data", dout, 8'h00);
        addr = 1'b1; #1 check("rst_stat", dout, 8'h00);
        check("rst_irq", {7'b0, irq}, 8'h00);
        reset = 1'b0;
        wait_clk(5);

        // Single good frame
        send_frame(8'h1C, 1'b1, 1'b1);
        reg_read(1'b1, rd); check("f1c_stat", rd, 8'h01);
        reg_read(1'b0, rd); check("f1c_data", rd, 8'h1C);
        reg_read(1'b1, rd); check("f1c_stat_after", rd, 8'h00);

        // Interrupt enable
        reg_write(1'b1, 8'h80);
        check("irq_idle", {7'b0, irq}, 8'h00);
        send_frame(8'hF0, 1'b1, 1'b1);
        check("irq_set", {7'b0, irq}, 8'h01);
        reg_read(1'b1, rd); check("f0_stat", rd, 8'h81);
        reg_read(1'b0, rd); check("f0_data", rd, 8'hF0);
        #1 check("irq_clear", {7'b0, irq}, 8'h00);
        reg_write(1'b1, 8'h00);

        // Overflow with five frames into a depth-4 FIFO
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        send_frame(8'h33, 1'b1, 1'b1);
        send_frame(8'h44, 1'b1, 1'b1);
        send_frame(8'h55, 1'b1, 1'b1);
        reg_read(1'b1, rd); check("ovr_stat", rd, 8'h03);
        reg_read(1'b0, rd); check("ovr_d0", rd, 8'h11);
        reg_read(1'b0, rd); check("ovr_d1", rd, 8'h22);
        reg_read(1'b0, rd); check("ovr_d2", rd, 8'h33);
        reg_read(1'b0, rd); check("ovr_d3", rd, 8'h44);
        reg_read(1'b1, rd); check("ovr_stat_empty", rd, 8'h02);
        reg_read(1'b0, rd); check("empty_read", rd, 8'h00);
        reg_write(1'b1, 8'h02);
        reg_read(1'b1, rd); check("ovr_cleared", rd, 8'h00);

        // Truncated frame then recovery
        send_bits({7'b0, 4'b1010}, 5);
        wait_clk(TO / 2);
        reg_read(1'b1, rd); check("tout_early", rd, 8'h00);
        wait_clk(TO);
        reg_read(1'b1, rd); check("tout_stat", rd, 8'h04);
        send_frame(8'h5A, 1'b1, 1'b1);
        reg_read(1'b1, rd); check("tout_5a_stat", rd, 8'h05);
        reg_read(1'b0, rd); check("tout_5a_data", rd, 8'h5A);
        reg_write(1'b1, 8'h04);
        reg_read(1'b1, rd); check("tout_cleared", rd, 8'h00);

        // Framing error
        send_frame(8'h33, 1'b1, 1'b0);
        reg_read(1'b1, rd); check("ferr_stat", rd, 8'h08);
        reg_write(1'b1, 8'h08);
        reg_read(1'b1, rd); check("ferr_cleared", rd, 8'h00);

        // Short clock glitches with data low must not start a frame
        ps2_dat = 1'b0;
        wait_clk(20);
        for (int i = 0; i < 4; i++) begin
            ps2_clk = 1'b0; wait_clk(5);
            ps2_clk = 1'b1; wait_clk(15);
        end
        ps2_dat = 1'b1;
        wait_clk(TO + 60);
        reg_read(1'b1, rd); check("glitch_stat", rd, 8'h00);
        send_frame(8'hA5, 1'b1, 1'b1);
        reg_read(1'b0, rd); check("glitch_a5", rd, 8'hA5);

        // Bad parity
        send_frame(8'h1C, 1'b0, 1'b1);
`ifdef PS2_PARITY_CHK_EN
        reg_read(1'b1, rd); check("perr_stat", rd, 8'h10);
        reg_write(1'b1, 8'h10);
        reg_read(1'b1, rd); check("perr_cleared", rd, 8'h00);
`else
        reg_read(1'b1, rd); check("nopar_stat", rd, 8'h01);
        reg_read(1'b0, rd); check("nopar_data", rd, 8'h1C);
`endif

        // Reset mid-frame with a byte queued and IE set
        reg_write(1'b1, 8'h80);
        send_frame(8'h77, 1'b1, 1'b1);
        check("pre_rst_irq", {7'b0, irq}, 8'h01);
        send_bits({8'h00, 3'b010}, 3);
        reset = 1'b1;
        wait_clk(2);
        addr = 1'b1; #1 check("mid_rst_stat", dout, 8'h00);
        check("mid_rst_irq", {7'b0, irq}, 8'h00);
        reset = 1'b0;
        wait_clk(5);
        send_frame(8'h3C, 1'b1, 1'b1);
        reg_read(1'b1, rd); check("post_rst_stat", rd, 8'h01);
        reg_read(1'b0, rd); check("post_rst_data", rd, 8'h3C);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ps2_rx.md
# ps2_rx

Receive-only PS/2 keyboard port with a byte FIFO and a CPU register interface. It sits between the board's PS/2 clock/data pins and the 6502 system bus inside the `tst_6502` system, and raises an interrupt while scan codes are waiting. The block does not drive the PS/2 lines; the top level leaves them released.

## Interface
- `CLK_HZ`, 16000000: system clock frequency; documentation only.
- `FILT_LEN`, 8: number of consecutive equal samples needed to accept a PS/2 line change (2..15).
- `TIMEOUT_CYC`, 16000: idle `clk` cycles mid-frame before the frame is aborted (1 ms at 16 MHz).
- `FIFO_AW`, 2: FIFO address width; depth is 2^`FIFO_AW`.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `cs`  in  1  register access strobe; one cycle per access.
- `we`  in  1  1 = write, 0 = read.
- `addr`  in  1  register select: 0 = DATA, 1 = STAT.
- `din`  in  8  write data.
- `dout`  out  8  read data; combinational from `addr` and flops.
- `irq`  out  1  interrupt request, active-high.
- `ps2_clk_i`  in  1  raw PS/2 clock pin.
- `ps2_dat_i`  in  1  raw PS/2 data pin.

## Operation
- **Input conditioning.**
  - Each pin passes through a 2-FF synchronizer, then a glitch filter.
  - The filtered value changes only after `FILT_LEN` consecutive synchronized samples differ from it.
  - Both filtered values reset to 1.
- **Bit strobe.** A bit strobe is a 1→0 transition of the filtered clock. The filtered data is sampled on that same cycle.
- **Frame FSM** (states IDLE, DATA, PARITY, STOP):
  - IDLE: a strobe with data 0 moves to DATA with the bit count cleared. A strobe with data 1 is ignored and the FSM stays in IDLE.
  - DATA: shifts in 8 bits, LSB first, then moves to PARITY.
  - PARITY: captures the parity bit, then moves to STOP.
  - STOP: the strobe returns the FSM to IDLE.
    - Stop bit 1 with parity OK: push the byte.
    - Stop bit 0: drop the byte and set FERR.
- **Timeout.**
  - In any non-IDLE state, a counter counts cycles since the last strobe.
  - When it reaches `TIMEOUT_CYC`, the FSM returns to IDLE, drops the partial byte and sets TOUT.
  - The counter is cleared on every strobe.
- **FIFO.**
  - Push on a good stop bit; pop on a DATA read.
  - Push while full, with no pop in the same cycle: the byte is dropped and OVR is set.
  - Push and pop in the same cycle: both happen, the count is unchanged, and OVR is not set even when full.
  - Pop while empty: no effect.
- **DATA register (addr 0).**
  - Read returns the FIFO head, or 0x00 when the FIFO is empty.
  - Read pops the FIFO on the `cs` cycle.
  - Write is ignored.
- **STAT register (addr 1).**
  - Read returns {IE, 3'b0, FERR, TOUT, OVR, RXF}, where RXF = FIFO not empty.
  - Write:
    - IE ← `din[7]`.
    - `din[1]`, `din[2]` and `din[3]` are write-1-to-clear for OVR, TOUT and FERR respectively.
    - A clear and a set of the same flag in the same cycle: the set wins.
- **Interrupt.** `irq` = IE & RXF. Both terms come from flops, so there is no combinational path from the bus inputs.

## Timing
- Reset values:
  - FSM = IDLE; FIFO empty; all flags and IE = 0.
  - `irq` = 0.
  - `dout` = 0x00 for both addresses.
- Line change to filtered change: 2 synchronizer cycles + `FILT_LEN` cycles.
- Push happens on the clock edge after the STOP strobe is detected. RXF and `irq` go high on the following cycle.
- Pop: the FIFO head advances at the clock edge that ends the `cs` read cycle. `dout` shows the new head on the next cycle.
- Pointer wrap is modulo 2^`FIFO_AW`. Full and empty are distinguished by a one-bit-wider count.
- `reset` asserted mid-frame or mid-access: everything returns to its reset value immediately. The frame in progress is lost.

## Configuration
- `PS2_PARITY_CHK_EN`:
  - Defined: the parity bit must make the 9 bits {parity, data} odd. On a mismatch the byte is dropped at STOP and PERR (STAT bit 4, write-1-to-clear via `din[4]`) is set.
  - Undefined: the parity bit is captured but ignored, and STAT bit 4 reads 0.

## Test plan
- Frame 0x1C with good parity and stop → RXF=1, DATA read = 0x1C, then RXF=0.
- IE=1, frame 0xF0 → `irq`=1 two cycles after the stop strobe. A DATA read drops `irq` on the next cycle.
- Five frames with no reads (depth 4) → the first four bytes are read in order and OVR=1. Writing 0x02 to STAT clears OVR.
- Frame truncated after 4 data bits → TOUT=1 after `TIMEOUT_CYC` cycles, nothing pushed. The next full frame 0x5A is received correctly.
- Stop bit 0 → FERR=1, FIFO empty. Glitches on `ps2_clk_i` shorter than `FILT_LEN` cycles → no bit strobe.
- With `PS2_PARITY_CHK_EN`: frame 0x1C with bad parity → PERR=1, FIFO empty. Without it: byte 0x1C is pushed.
